// File: rtl/acc_result_collector.sv
// acc_result_collector
//   Filters the accumulator's result stream down to the final group sums
//   (beats flagged with tlast), buffers them in a small circular FIFO and
//   re-emits them on an AXI-Stream master with backpressure.
//   Output words are framed into packets of GROUPS_PER_PACKET results.
//
// Ports
//   aclk, aresetn   clock (rising edge), asynchronous active-low reset
//   aclken          clock enable; 0 freezes all state and the output handshake
//   s_axis_*        accumulator result stream (no backpressure)
//   m_axis_*        buffered final sums, tready backpressure
//   fill_count      entries held, including the one on the output
//   overflow        sticky flag: a final sum was dropped because the FIFO was full
module acc_result_collector #(
   parameter int unsigned DATA_WIDTH        = 16,
   parameter int unsigned TUSER_WIDTH       = 4,
   parameter int unsigned FIFO_DEPTH        = 4,
   parameter int unsigned GROUPS_PER_PACKET = 3
) (
   input  logic                          aclk,
   input  logic                          aresetn,
   input  logic                          aclken,
   input  logic                          s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
   input  logic                          s_axis_tlast,
   input  logic [TUSER_WIDTH-1:0]        s_axis_tuser,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic [DATA_WIDTH-1:0]         m_axis_tdata,
   output logic [TUSER_WIDTH-1:0]        m_axis_tuser,
   output logic                          m_axis_tlast,
   output logic [$clog2(FIFO_DEPTH):0]   fill_count,
   output logic                          overflow
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam int unsigned PktW = (GROUPS_PER_PACKET > 1) ? $clog2(GROUPS_PER_PACKET) : 1;

   logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]        fill_q, fill_d;
   logic [PktW-1:0]        pkt_cnt_q, pkt_cnt_d;
   logic                   overflow_q, overflow_d;

   logic [DATA_WIDTH-1:0]  data_mem [FIFO_DEPTH];
   logic [TUSER_WIDTH-1:0] user_mem [FIFO_DEPTH];

   logic push_req, push, pop, full, last_of_pkt;

   assign full        = (fill_q == CntW'(FIFO_DEPTH));
   assign push_req    = aclken & s_axis_tvalid & s_axis_tlast;
   assign pop         = aclken & m_axis_tvalid & m_axis_tready;
   // When full, a push is only accepted if a pop frees the slot on the same edge.
   assign push        = push_req & (~full | pop);
   assign last_of_pkt = (pkt_cnt_q == PktW'(GROUPS_PER_PACKET - 1));

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fill_d     = fill_q;
      pkt_cnt_d  = pkt_cnt_q;
      overflow_d = overflow_q;

      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop) begin
         rd_ptr_d  = rd_ptr_q + PtrW'(1);
         pkt_cnt_d = last_of_pkt ? '0 : pkt_cnt_q + PktW'(1);
      end

      case ({push, pop})
         2'b10:   fill_d = fill_q + CntW'(1);
         2'b01:   fill_d = fill_q - CntW'(1);
         default: fill_d = fill_q;
      endcase

      if (push_req && !push) overflow_d = 1'b1;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fill_q     <= '0;
         pkt_cnt_q  <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fill_q     <= fill_d;
         pkt_cnt_q  <= pkt_cnt_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; the output mux below masks it whenever the FIFO is empty.
   always_ff @(posedge aclk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= s_axis_tdata;
         user_mem[wr_ptr_q] <= s_axis_tuser;
      end
   end

   assign m_axis_tvalid = (fill_q != '0);
   assign m_axis_tdata  = m_axis_tvalid ? data_mem[rd_ptr_q] : '0;
   assign m_axis_tuser  = m_axis_tvalid ? user_mem[rd_ptr_q] : '0;
   assign m_axis_tlast  = last_of_pkt & m_axis_tvalid;
   assign fill_count    = fill_q;
   assign overflow      = overflow_q;

endmodule
